// File: rtl/dma_pkg.sv
// Shared widths, FSM state type and byte-lane helper for the DMA copy engine.
package dma_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int MEM_ADDR_WIDTH = 10;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_STRB_WIDTH = 4;
  localparam int FIFO_BYTES     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dma_state_e;

  // cnt contiguous lanes starting at lane off; off + cnt never exceeds 4
  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [2:0] cnt);
    logic [3:0] m;
    m = 4'((5'd1 << cnt) - 5'd1);
    return m << off;
  endfunction

endpackage

// File: rtl/dma_byte_fifo.sv
// Byte-wide staging FIFO accepting and releasing 0..4 bytes per cycle.
module dma_byte_fifo
  import dma_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  push_cnt,
  input  logic [31:0] push_data,
  input  logic [2:0]  pop_cnt,
  output logic [31:0] peek_data,
  output logic [3:0]  count
);

  localparam int PW = $clog2(FIFO_BYTES);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [FIFO_BYTES];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PW'(pop_cnt);
      wr_ptr_q <= wr_ptr_q + PW'(push_cnt);
      count_q  <= count_q + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  // Storage needs no reset: occupancy alone decides which bytes are valid
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (PW'(i) < PW'(push_cnt) || push_cnt == 3'd4)
        mem_q[wr_ptr_q + PW'(i)] <= push_data[8*i +: 8];
    end
  end

  always_comb begin
    peek_data = '0;
    for (int i = 0; i < 4; i++)
      peek_data[8*i +: 8] = mem_q[rd_ptr_q + PW'(i)];
  end

  assign count = 4'(count_q);

endmodule

// File: rtl/dma_copy_engine.sv
// Byte-granular SRAM-to-SRAM copy: word reads from mem0, realigned through a byte FIFO,
// lane-masked word writes to mem1.
//  state | meaning
//  IDLE  | waiting for start, config not held
//  RUN   | reader and writer active
//  DONE  | one-cycle completion pulse
module dma_copy_engine
  import dma_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  input  logic [REG_DATA_WIDTH-1:0] src_addr,
  input  logic [REG_DATA_WIDTH-1:0] dst_addr,
  input  logic [REG_DATA_WIDTH-1:0] size,
  output logic                      busy,
  output logic                      done,
  output logic                      mem0_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem0_addr,
  input  logic [MEM_DATA_WIDTH-1:0] mem0_rdata,
  output logic                      mem1_en,
  output logic [MEM_STRB_WIDTH-1:0] mem1_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem1_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem1_wdata
);

  dma_state_e state_q, state_d;
  logic [REG_DATA_WIDTH-1:0] rd_rem_q, rd_rem_d, wr_rem_q, wr_rem_d;
  logic [MEM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic       rd_first_q, rd_first_d, wr_first_q, wr_first_d;
  logic [1:0] src_off_q, src_off_d, dst_off_q, dst_off_d;
  logic [2:0] infl_cnt_q, infl_cnt_d;
  logic [1:0] infl_lane_q, infl_lane_d;

  logic [1:0]  rd_off, wr_off;
  logic [2:0]  rd_room, rd_bytes, wr_room, wr_chunk;
  logic        rd_go, wr_go;
  logic [3:0]  fifo_count, wr_mask;
  logic [4:0]  fifo_used;
  logic [31:0] fifo_peek, push_data, wr_shift, lane_bytes;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^{src_addr[REG_DATA_WIDTH-1:MEM_ADDR_WIDTH+2],
                            dst_addr[REG_DATA_WIDTH-1:MEM_ADDR_WIDTH+2]};

  dma_byte_fifo u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push_cnt  (infl_cnt_q),
    .push_data (push_data),
    .pop_cnt   (wr_go ? wr_chunk : 3'd0),
    .peek_data (fifo_peek),
    .count     (fifo_count)
  );

  always_comb begin
    rd_off    = rd_first_q ? src_off_q : 2'd0;
    rd_room   = 3'd4 - {1'b0, rd_off};
    rd_bytes  = (rd_rem_q < REG_DATA_WIDTH'(rd_room)) ? rd_rem_q[2:0] : rd_room;
    // In-flight bytes already own FIFO space, so the reader never overruns it
    fifo_used = {1'b0, fifo_count} + {2'b00, infl_cnt_q};
    rd_go     = (state_q == RUN) && (rd_rem_q != '0) && (fifo_used <= 5'(FIFO_BYTES - 4));

    wr_off    = wr_first_q ? dst_off_q : 2'd0;
    wr_room   = 3'd4 - {1'b0, wr_off};
    wr_chunk  = (wr_rem_q < REG_DATA_WIDTH'(wr_room)) ? wr_rem_q[2:0] : wr_room;
    wr_go     = (state_q == RUN) && (wr_rem_q != '0) && (fifo_count >= {1'b0, wr_chunk});
    wr_mask   = wr_go ? lane_mask(wr_off, wr_chunk) : 4'd0;
    wr_shift  = fifo_peek << {wr_off, 3'b000};

    lane_bytes = '0;
    for (int i = 0; i < MEM_STRB_WIDTH; i++)
      lane_bytes[8*i +: 8] = {8{wr_mask[i]}};

    push_data = mem0_rdata >> {infl_lane_q, 3'b000};
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign mem0_en    = rd_go;
  assign mem0_addr  = rd_go ? rd_addr_q : '0;
  assign mem1_en    = wr_go;
  assign mem1_we    = wr_mask;
  assign mem1_addr  = wr_go ? wr_addr_q : '0;
  assign mem1_wdata = wr_shift & lane_bytes;

  always_comb begin
    state_d     = state_q;
    rd_rem_d    = rd_rem_q;
    wr_rem_d    = wr_rem_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    rd_first_d  = rd_first_q;
    wr_first_d  = wr_first_q;
    src_off_d   = src_off_q;
    dst_off_d   = dst_off_q;
    infl_cnt_d  = rd_go ? rd_bytes : 3'd0;
    infl_lane_d = rd_off;

    case (state_q)
      IDLE: begin
        if (start) begin
          rd_rem_d   = size;
          wr_rem_d   = size;
          rd_addr_d  = src_addr[MEM_ADDR_WIDTH+1:2];
          wr_addr_d  = dst_addr[MEM_ADDR_WIDTH+1:2];
          src_off_d  = src_addr[1:0];
          dst_off_d  = dst_addr[1:0];
          rd_first_d = 1'b1;
          wr_first_d = 1'b1;
          state_d    = (size == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (rd_go) begin
          rd_rem_d   = rd_rem_q - REG_DATA_WIDTH'(rd_bytes);
          rd_addr_d  = rd_addr_q + 1'b1;
          rd_first_d = 1'b0;
        end
        if (wr_go) begin
          wr_rem_d   = wr_rem_q - REG_DATA_WIDTH'(wr_chunk);
          wr_addr_d  = wr_addr_q + 1'b1;
          wr_first_d = 1'b0;
          if (wr_rem_q == REG_DATA_WIDTH'(wr_chunk)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      rd_rem_q    <= '0;
      wr_rem_q    <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      rd_first_q  <= 1'b0;
      wr_first_q  <= 1'b0;
      src_off_q   <= '0;
      dst_off_q   <= '0;
      infl_cnt_q  <= '0;
      infl_lane_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_rem_q    <= rd_rem_d;
      wr_rem_q    <= wr_rem_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      rd_first_q  <= rd_first_d;
      wr_first_q  <= wr_first_d;
      src_off_q   <= src_off_d;
      dst_off_q   <= dst_off_d;
      infl_cnt_q  <= infl_cnt_d;
      infl_lane_q <= infl_lane_d;
    end
  end

endmodule
